// File: rtl/serial_prog_loader_pkg.sv
// Shared encodings and defaults for the serial boot loader and its UART receiver.
package serial_prog_loader_pkg;

  localparam int DEF_BIT_CNT   = 100;
  localparam int DEF_MAX_BYTES = 32768;
  localparam int HDR_BYTES     = 4;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    LD_HDR,
    LD_LOAD,
    LD_FLUSH,
    LD_DONE
  } ld_state_t;

  function automatic logic [31:0] lane_insert(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [7:0]  b);
    logic [31:0] w;
    w = word;
    case (lane)
      2'd0:    w[7:0]   = b;
      2'd1:    w[15:8]  = b;
      2'd2:    w[23:16] = b;
      default: w[31:24] = b;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/serial_prog_loader_if.sv
// Serial input and memory-init write port of the boot loader.
interface serial_prog_loader_if;
  logic        w_rxd;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic        r_we;
  logic        r_done;
  logic        r_err;

  modport master (
    input  w_rxd,
    output r_addr, r_data, r_we, r_done, r_err
  );

  modport slave (
    output w_rxd,
    input  r_addr, r_data, r_we, r_done, r_err
  );
endinterface

// File: rtl/serial_prog_loader_uart_rx_byte.sv
// 8N1 UART receiver: one-cycle byte valid and one-cycle framing-error pulse.
//   state    | meaning
//   RX_IDLE  | line idle, waiting for a low sample
//   RX_START | half-bit wait, confirm start bit (high = glitch)
//   RX_DATA  | sample 8 data bits LSB first, one per bit period
//   RX_STOP  | sample stop bit; on a bad stop, hold until the line is high
module uart_rx_byte
  import serial_prog_loader_pkg::*;
#(
  parameter int BIT_CNT = DEF_BIT_CNT
) (
  input  logic       w_clk,
  input  logic       w_rst,
  input  logic       w_rxd,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_ferr
);

  localparam int CW = $clog2(BIT_CNT);
  localparam logic [CW-1:0] FULL = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] HALF = CW'(BIT_CNT / 2 - 1);

  rx_state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          valid_q, valid_n;
  logic          ferr_q, ferr_n;
  logic          stop_fail, stop_fail_n;
  logic          tc;

  assign tc = (cnt == '0);

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state     <= RX_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      stop_fail <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shreg     <= shreg_n;
      valid_q   <= valid_n;
      ferr_q    <= ferr_n;
      stop_fail <= stop_fail_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    idx_n       = idx;
    shreg_n     = shreg;
    valid_n     = 1'b0;
    ferr_n      = 1'b0;
    stop_fail_n = stop_fail;
    case (state)
      RX_IDLE: begin
        if (!w_rxd) begin
          state_n = RX_START;
          cnt_n   = HALF;
          idx_n   = '0;
        end
      end
      RX_START: begin
        if (!tc) begin
          cnt_n = cnt - CW'(1);
        end else if (!w_rxd) begin
          state_n = RX_DATA;
          cnt_n   = FULL;
        end else begin
          state_n = RX_IDLE;
        end
      end
      RX_DATA: begin
        if (!tc) begin
          cnt_n = cnt - CW'(1);
        end else begin
          shreg_n = {w_rxd, shreg[7:1]};
          cnt_n   = FULL;
          if (idx == 3'd7) state_n = RX_STOP;
          else             idx_n   = idx + 3'd1;
        end
      end
      RX_STOP: begin
        if (!tc) begin
          cnt_n = cnt - CW'(1);
        end else if (w_rxd) begin
          state_n     = RX_IDLE;
          valid_n     = !stop_fail;
          stop_fail_n = 1'b0;
        end else if (!stop_fail) begin
          // report once, then park here until the line returns high
          ferr_n      = 1'b1;
          stop_fail_n = 1'b1;
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

  assign rx_byte  = shreg;
  assign rx_valid = valid_q;
  assign rx_ferr  = ferr_q;

endmodule

// File: rtl/serial_prog_loader.sv
// Serial boot loader: length-prefixed byte stream packed into little-endian word writes.
//   state    | meaning
//   LD_HDR   | collecting the 4-byte little-endian length
//   LD_LOAD  | packing payload bytes into words, strobing each full word
//   LD_FLUSH | strobe cycle of the final partial word
//   LD_DONE  | image written; done is sticky, further bytes ignored
module serial_prog_loader
  import serial_prog_loader_pkg::*;
#(
  parameter int BIT_CNT   = DEF_BIT_CNT,
  parameter int MAX_BYTES = DEF_MAX_BYTES
) (
  input  logic                  w_clk,
  input  logic                  w_rst,
  serial_prog_loader_if.master  bus
);

  localparam logic [31:0] MAX_LEN = 32'(MAX_BYTES);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ferr;

  uart_rx_byte #(
    .BIT_CNT (BIT_CNT)
  ) u_rx (
    .w_clk    (w_clk),
    .w_rst    (w_rst),
    .w_rxd    (bus.w_rxd),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr)
  );

  ld_state_t   state, state_n;
  logic [1:0]  hdr_idx, hdr_idx_n;
  logic [31:0] hdr_buf, hdr_buf_n;
  logic [31:0] len, len_n;
  logic [31:0] byte_cnt, byte_cnt_n;
  logic [31:0] word_buf, word_buf_n;
  logic [31:0] wr_addr, wr_addr_n;
  logic [31:0] addr_q, addr_n;
  logic [31:0] data_q, data_n;
  logic        we_q, we_n;
  logic        done_q, done_n;
  logic        err_q, err_n;

  logic [31:0] hdr_full;
  logic [31:0] word_new;
  logic [31:0] cnt_inc;

  assign hdr_full = {rx_byte, hdr_buf[31:8]};
  assign word_new = lane_insert(word_buf, byte_cnt[1:0], rx_byte);
  assign cnt_inc  = byte_cnt + 32'd1;

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state    <= LD_HDR;
      hdr_idx  <= '0;
      hdr_buf  <= '0;
      len      <= '0;
      byte_cnt <= '0;
      word_buf <= '0;
      wr_addr  <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      hdr_idx  <= hdr_idx_n;
      hdr_buf  <= hdr_buf_n;
      len      <= len_n;
      byte_cnt <= byte_cnt_n;
      word_buf <= word_buf_n;
      wr_addr  <= wr_addr_n;
      addr_q   <= addr_n;
      data_q   <= data_n;
      we_q     <= we_n;
      done_q   <= done_n;
      err_q    <= err_n;
    end
  end

  always_comb begin
    state_n    = state;
    hdr_idx_n  = hdr_idx;
    hdr_buf_n  = hdr_buf;
    len_n      = len;
    byte_cnt_n = byte_cnt;
    word_buf_n = word_buf;
    wr_addr_n  = wr_addr;
    addr_n     = addr_q;
    data_n     = data_q;
    we_n       = 1'b0;
    err_n      = err_q | rx_ferr;
    // done follows the final strobe by one cycle in both the full and partial case
    done_n     = done_q | (state == LD_FLUSH) | (state == LD_DONE);
    case (state)
      LD_HDR: begin
        if (rx_valid) begin
          hdr_buf_n = hdr_full;
          hdr_idx_n = hdr_idx + 2'd1;
          if (hdr_idx == 2'(HDR_BYTES - 1)) begin
            byte_cnt_n = '0;
            if (hdr_full == '0) begin
              state_n = LD_DONE;
              done_n  = 1'b1;
            end else if (hdr_full > MAX_LEN) begin
              len_n   = MAX_LEN;
              err_n   = 1'b1;
              state_n = LD_LOAD;
            end else begin
              len_n   = hdr_full;
              state_n = LD_LOAD;
            end
          end
        end
      end
      LD_LOAD: begin
        if (rx_valid) begin
          byte_cnt_n = cnt_inc;
          if ((byte_cnt[1:0] == 2'd3) || (cnt_inc == len)) begin
            we_n       = 1'b1;
            data_n     = word_new;
            addr_n     = wr_addr;
            wr_addr_n  = wr_addr + 32'd4;
            word_buf_n = '0;
            if (cnt_inc == len) state_n = (len[1:0] == 2'd0) ? LD_DONE : LD_FLUSH;
          end else begin
            word_buf_n = word_new;
          end
        end
      end
      LD_FLUSH: state_n = LD_DONE;
      LD_DONE:  state_n = LD_DONE;
      default:  state_n = LD_HDR;
    endcase
  end

  assign bus.r_addr = addr_q;
  assign bus.r_data = data_q;
  assign bus.r_we   = we_q;
  assign bus.r_done = done_q;
  assign bus.r_err  = err_q;

endmodule

// File: tb/tb_serial_prog_loader.sv
// Bench for the serial boot loader: vector table, corner sequences, randomized images vs a stream model.
module tb_serial_prog_loader;

  localparam int BIT  = 10;
  localparam int MAXB = 16;

  logic w_clk = 1'b0;
  logic w_rst = 1'b1;

  serial_prog_loader_if bus();

  serial_prog_loader #(
    .BIT_CNT   (BIT),
    .MAX_BYTES (MAXB)
  ) dut (
    .w_clk (w_clk),
    .w_rst (w_rst),
    .bus   (bus)
  );

  always #5 w_clk = ~w_clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge w_clk) cyc <= cyc + 1;

  // observed writes
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          wc_q[$];
  int          done_cyc = -1;
  logic        prev_we = 1'b0;
  logic        prev_done = 1'b0;

  // expected writes
  logic [31:0] exp_a[$];
  logic [31:0] exp_d[$];
  logic        exp_err;
  logic [7:0]  stim[$];
  int          last_start;

  always @(negedge w_clk) begin
    if (bus.r_we === 1'b1) begin
      tests++;
      if (prev_we === 1'b1) begin
        fails++;
        $display("FAIL we_consecutive: r_we high two cycles running at cycle %0d", cyc);
      end
      wa_q.push_back(bus.r_addr);
      wd_q.push_back(bus.r_data);
      wc_q.push_back(cyc);
    end
    if (bus.r_done === 1'b1 && prev_done !== 1'b1) done_cyc = cyc;
    prev_we   = bus.r_we;
    prev_done = bus.r_done;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    w_rst     = 1'b1;
    bus.w_rxd = 1'b1;
    repeat (2) @(negedge w_clk);
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    done_cyc = -1;
    w_rst = 1'b0;
    @(negedge w_clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic good);
    @(negedge w_clk);
    last_start = cyc;
    bus.w_rxd = 1'b0;
    repeat (BIT) @(negedge w_clk);
    for (int i = 0; i < 8; i++) begin
      bus.w_rxd = b[i];
      repeat (BIT) @(negedge w_clk);
    end
    bus.w_rxd = good;
    repeat (BIT) @(negedge w_clk);
    bus.w_rxd = 1'b1;
    repeat (good ? 2 : BIT) @(negedge w_clk);
  endtask

  task automatic send_header(input logic [31:0] n);
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], 1'b1);
  endtask

  task automatic send_stim();
    for (int i = 0; i < stim.size(); i++) send_byte(stim[i], 1'b1);
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (bus.r_done !== 1'b1 && k < budget) begin
      @(negedge w_clk);
      k++;
    end
    check("done_within_budget", {31'd0, bus.r_done}, 32'd1);
  endtask

  // image model: length from first 4 bytes, clamp, then little-endian words of the payload
  task automatic model();
    logic [31:0] n;
    logic [31:0] w;
    int          nw;
    int          idx;
    exp_a.delete();
    exp_d.delete();
    n = {stim[3], stim[2], stim[1], stim[0]};
    exp_err = 1'b0;
    if (n > MAXB) begin
      n = MAXB;
      exp_err = 1'b1;
    end
    nw = (int'(n) + 3) / 4;
    for (int k = 0; k < nw; k++) begin
      w = '0;
      for (int l = 0; l < 4; l++) begin
        idx = 4 * k + l;
        if (idx < int'(n) && 4 + idx < stim.size()) w = w | (32'(stim[4 + idx]) << (8 * l));
      end
      exp_a.push_back(32'(4 * k));
      exp_d.push_back(w);
    end
  endtask

  task automatic verify(input string name, input logic err);
    int m;
    check({name, "_nwrites"}, 32'(wd_q.size()), 32'(exp_d.size()));
    m = (wd_q.size() < exp_d.size()) ? wd_q.size() : exp_d.size();
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s_addr%0d", name, i), wa_q[i], exp_a[i]);
      check($sformatf("%s_data%0d", name, i), wd_q[i], exp_d[i]);
    end
    check({name, "_err"}, {31'd0, bus.r_err}, {31'd0, err});
    check({name, "_done"}, {31'd0, bus.r_done}, 32'd1);
    if (m > 0) begin
      check({name, "_done_latency"}, 32'(done_cyc - wc_q[wc_q.size() - 1]), 32'd1);
      check({name, "_data_hold"}, bus.r_data, exp_d[exp_d.size() - 1]);
      check({name, "_addr_hold"}, bus.r_addr, exp_a[exp_a.size() - 1]);
    end
  endtask

  typedef struct {
    logic [31:0] n;
    int          plen;
    logic [63:0] pay;
    int          nwr;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        err;
  } vec_t;

  vec_t tv[5];

  initial begin
    tv[0] = '{32'd8, 8, 64'h8877665544332211, 2, 32'h44332211, 32'h88776655, 1'b0};
    tv[1] = '{32'd5, 5, 64'h000000EEDDCCBBAA, 2, 32'hDDCCBBAA, 32'h000000EE, 1'b0};
    tv[2] = '{32'd1, 1, 64'h000000000000005A, 1, 32'h0000005A, 32'h0,        1'b0};
    tv[3] = '{32'd3, 3, 64'h0000000000030201, 1, 32'h00030201, 32'h0,        1'b0};
    tv[4] = '{32'd4, 4, 64'h00000000EFBEADDE, 1, 32'hEFBEADDE, 32'h0,        1'b0};

    bus.w_rxd = 1'b1;
    w_rst     = 1'b1;
    repeat (3) @(negedge w_clk);
    check("rst_addr", bus.r_addr, 32'd0);
    check("rst_data", bus.r_data, 32'd0);
    check("rst_we",   {31'd0, bus.r_we},   32'd0);
    check("rst_done", {31'd0, bus.r_done}, 32'd0);
    check("rst_err",  {31'd0, bus.r_err},  32'd0);

    for (int v = 0; v < 5; v++) begin
      do_reset();
      send_header(tv[v].n);
      for (int i = 0; i < tv[v].plen; i++) send_byte(tv[v].pay[8*i +: 8], 1'b1);
      wait_done(40);
      exp_a.delete();
      exp_d.delete();
      if (tv[v].nwr > 0) begin exp_a.push_back(32'd0); exp_d.push_back(tv[v].w0); end
      if (tv[v].nwr > 1) begin exp_a.push_back(32'd4); exp_d.push_back(tv[v].w1); end
      verify($sformatf("vec%0d", v), tv[v].err);
    end

    // empty image: done within the last header byte's frame, later bytes ignored
    do_reset();
    send_header(32'd0);
    check("n0_done", {31'd0, bus.r_done}, 32'd1);
    check("n0_done_window", {31'd0, (done_cyc >= last_start + 90) && (done_cyc <= last_start + 100)}, 32'd1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    check("n0_no_writes", 32'(wd_q.size()), 32'd0);
    check("n0_err", {31'd0, bus.r_err}, 32'd0);

    // framing error mid-payload: byte dropped, next byte takes its lane
    do_reset();
    send_header(32'd4);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'hFF, 1'b0);
    check("ferr_err_set", {31'd0, bus.r_err}, 32'd1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    wait_done(40);
    exp_a.delete(); exp_d.delete();
    exp_a.push_back(32'd0); exp_d.push_back(32'h04030201);
    verify("ferr", 1'b1);

    // short low glitch on the idle line
    do_reset();
    @(negedge w_clk);
    bus.w_rxd = 1'b0;
    repeat (3) @(negedge w_clk);
    bus.w_rxd = 1'b1;
    repeat (200) @(negedge w_clk);
    check("glitch_err", {31'd0, bus.r_err}, 32'd0);
    check("glitch_no_writes", 32'(wd_q.size()), 32'd0);
    stim = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40};
    send_stim();
    wait_done(40);
    model();
    verify("glitch_img", 1'b0);

    // async reset mid-word, then a fresh 4-byte image
    do_reset();
    send_header(32'd8);
    send_byte(8'h01, 1'b1);
    send_byte(8'h55, 1'b0);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h06, 1'b1);
    check("mid_pre_data", bus.r_data, 32'h04030201);
    check("mid_pre_err", {31'd0, bus.r_err}, 32'd1);
    @(negedge w_clk);
    #2 w_rst = 1'b1;
    #1;
    check("mid_async_data", bus.r_data, 32'd0);
    check("mid_async_addr", bus.r_addr, 32'd0);
    check("mid_async_err", {31'd0, bus.r_err}, 32'd0);
    check("mid_async_we", {31'd0, bus.r_we}, 32'd0);
    do_reset();
    stim = '{8'h04, 8'h00, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_stim();
    wait_done(40);
    exp_a.delete(); exp_d.delete();
    exp_a.push_back(32'd0); exp_d.push_back(32'hEFBEADDE);
    verify("mid_fresh", 1'b0);

    // oversize header clamps to MAXB bytes
    do_reset();
    stim.delete();
    stim = '{8'd20, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 22; i++) stim.push_back(8'(8'h80 + i));
    send_stim();
    wait_done(40);
    model();
    verify("clamp", exp_err);
    check("clamp_model_err", {31'd0, exp_err}, 32'd1);

    // randomized images
    for (int r = 0; r < 8; r++) begin
      int n;
      int plen;
      n = int'($urandom_range(1, 18));
      plen = ((n > MAXB) ? MAXB : n) + int'($urandom_range(0, 2));
      stim.delete();
      stim.push_back(8'(n));
      stim.push_back(8'h00);
      stim.push_back(8'h00);
      stim.push_back(8'h00);
      for (int i = 0; i < plen; i++) stim.push_back(8'($urandom));
      do_reset();
      send_stim();
      wait_done(40);
      model();
      verify($sformatf("rnd%0d", r), exp_err);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
